// File: rtl/if_id_pkg.sv
// Shared types and defaults for the IF/ID skid stage.
package if_id_pkg;

    localparam int unsigned INST_W_DEF = 32;
    localparam int unsigned PC_W_DEF   = 64;
    localparam int unsigned CNT_W_DEF  = 32;

    // addi x0,x0,0: what decode sees while the stage holds nothing
    localparam logic [31:0] BUBBLE_INST_DEF = 32'h00000013;

    typedef struct packed {
        logic [INST_W_DEF-1:0] inst;
        logic [PC_W_DEF-1:0]   pc;
    } if_id_beat_t;

    // Occupancy of the two entries; skid is never full while main is empty
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_FULL  = 2'd2
    } occ_state_e;

endpackage

// File: rtl/if_id_skid_stage_if.sv
// Fetch-side and decode-side valid/ready handshake of the IF/ID stage.
interface if_id_skid_stage_if #(
    parameter int unsigned INST_W = 32,
    parameter int unsigned PC_W   = 64
) ();

    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] in_inst;
    logic [PC_W-1:0]   in_pc;

    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [PC_W-1:0]   out_pc;

    // Environment side: fetch drives beats in, decode accepts beats out
    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_inst, out_pc
    );

    // Pipeline stage side
    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_inst, out_pc
    );

endinterface

// File: rtl/pipe_sat_cnt.sv
// Saturating event counter: holds at all-ones, cleared by reset or clr.
module pipe_sat_cnt #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline stage with main + skid entries and a registered in_ready.
// Optional perf counters (stall_cnt/flush_cnt) enabled by defining IF_ID_PERF_CNT_EN.
module if_id_skid_stage
    import if_id_pkg::*;
#(
    parameter int unsigned       INST_W      = INST_W_DEF,
    parameter int unsigned       PC_W        = PC_W_DEF,
    parameter logic [INST_W-1:0] BUBBLE_INST = INST_W'(BUBBLE_INST_DEF)
`ifdef IF_ID_PERF_CNT_EN
   ,parameter int unsigned       CNT_W       = CNT_W_DEF
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    if_id_skid_stage_if.slave bus
`ifdef IF_ID_PERF_CNT_EN
   ,output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    occ_state_e        state_q, state_d;
    logic [INST_W-1:0] main_inst_q, main_inst_d;
    logic [PC_W-1:0]   main_pc_q,   main_pc_d;
    logic [INST_W-1:0] skid_inst_q, skid_inst_d;
    logic [PC_W-1:0]   skid_pc_q,   skid_pc_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q,  in_ready_d;
    logic              acc;
    logic              pop;

    // Next occupancy and entry contents
    always_comb begin
        state_d     = state_q;
        main_inst_d = main_inst_q;
        main_pc_d   = main_pc_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        acc         = bus.in_valid & in_ready_q;
        pop         = out_valid_q & bus.out_ready;

        if (flush) begin
            // accepted beat is swallowed along with everything held
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        main_inst_d = bus.in_inst;
                        main_pc_d   = bus.in_pc;
                        state_d     = ST_MAIN;
                    end
                end
                ST_MAIN: begin
                    if (pop) begin
                        if (acc) begin
                            main_inst_d = bus.in_inst;
                            main_pc_d   = bus.in_pc;
                        end else begin
                            state_d = ST_EMPTY;
                        end
                    end else if (acc) begin
                        skid_inst_d = bus.in_inst;
                        skid_pc_d   = bus.in_pc;
                        state_d     = ST_FULL;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the skid can refill main
                    if (pop) begin
                        main_inst_d = skid_inst_q;
                        main_pc_d   = skid_pc_q;
                        state_d     = ST_MAIN;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        // Main doubles as the output register, so park the bubble in it when empty
        if (state_d == ST_EMPTY) begin
            main_inst_d = BUBBLE_INST;
            main_pc_d   = '0;
        end

        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_inst_q <= BUBBLE_INST;
            main_pc_q   <= '0;
            skid_inst_q <= '0;
            skid_pc_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_inst_q <= main_inst_d;
            main_pc_q   <= main_pc_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_inst  = main_inst_q;
    assign bus.out_pc    = main_pc_q;

`ifdef IF_ID_PERF_CNT_EN
    // Counters survive flush; only reset clears them
    pipe_sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (out_valid_q & ~bus.out_ready),
        .cnt   (stall_cnt)
    );

    pipe_sat_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (flush),
        .cnt   (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Scoreboard bench for if_id_skid_stage: the stage is modelled as a 2-deep FIFO of beats.
module tb_if_id_skid_stage;
    import if_id_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    always #5 clk = ~clk;

    if_id_skid_stage_if #(.INST_W(32), .PC_W(64)) bus ();

    int n_checks = 0;
    int n_fail   = 0;

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
    logic [1:0]  stall_cnt2, flush_cnt2;

    if_id_skid_stage_if #(.INST_W(32), .PC_W(64)) bus2 ();
    assign bus2.in_valid  = bus.in_valid;
    assign bus2.in_inst   = bus.in_inst;
    assign bus2.in_pc     = bus.in_pc;
    assign bus2.out_ready = bus.out_ready;

    if_id_skid_stage #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    if_id_skid_stage #(.CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus2),
        .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
    );
`else
    if_id_skid_stage dut (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus)
    );
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: beats accepted but not yet taken by decode, oldest first
    if_id_beat_t      q[$];
    logic [63:0]      emitted[$];
    longint unsigned  stall_m = 0;
    longint unsigned  flush_m = 0;

    function automatic int count_pc(input logic [63:0] p);
        int n = 0;
        foreach (emitted[i]) if (emitted[i] == p) n++;
        return n;
    endfunction

    function automatic logic [31:0] inst_of(input logic [63:0] p);
        return p[31:0] ^ 32'hA5A5_0F0F;
    endfunction

    // Monitor: compare DUT against the model before each edge, then advance the model
    always @(posedge clk) begin
        if_id_beat_t b;
        bit acc_m, pop_m;
        if (reset) begin
            q.delete();
            stall_m = 0;
            flush_m = 0;
        end else begin
            check("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
            check("in_ready",  64'(bus.in_ready),  64'(q.size() < 2));
            if (q.size() > 0) begin
                check("out_inst", 64'(bus.out_inst), 64'(q[0].inst));
                check("out_pc",   bus.out_pc,        q[0].pc);
            end else begin
                check("bubble_inst", 64'(bus.out_inst), 64'(BUBBLE_INST_DEF));
                check("bubble_pc",   bus.out_pc,        64'd0);
            end
`ifdef IF_ID_PERF_CNT_EN
            check("stall_cnt",  64'(stall_cnt),  64'(stall_m > 32'hFFFF_FFFF ? 32'hFFFF_FFFF : stall_m));
            check("flush_cnt",  64'(flush_cnt),  64'(flush_m > 32'hFFFF_FFFF ? 32'hFFFF_FFFF : flush_m));
            check("stall_cnt2", 64'(stall_cnt2), 64'(stall_m > 3 ? 3 : stall_m));
            check("flush_cnt2", 64'(flush_cnt2), 64'(flush_m > 3 ? 3 : flush_m));
            if (q.size() > 0 && !bus.out_ready) stall_m++;
            if (flush) flush_m++;
`endif
            acc_m = bus.in_valid && (q.size() < 2);
            pop_m = (q.size() > 0) && bus.out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (pop_m) begin
                    emitted.push_back(q[0].pc);
                    void'(q.pop_front());
                end
                if (acc_m) begin
                    b.inst = bus.in_inst;
                    b.pc   = bus.in_pc;
                    q.push_back(b);
                end
            end
        end
    end

    // One cycle of stimulus: inputs change on the falling edge
    task automatic drive(input bit v, input logic [63:0] p);
        bus.in_valid = v;
        bus.in_pc    = p;
        bus.in_inst  = inst_of(p);
        @(negedge clk);
    endtask

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inst   = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_out_inst",  64'(bus.out_inst),  64'h13);
        check("rst_out_pc",    bus.out_pc,         64'd0);

        // Streaming at full rate
        bus.out_ready = 1'b1;
        drive(1, 64'h0);
        check("stream_latency_pc", bus.out_pc, 64'h0);
        drive(1, 64'h4);
        drive(1, 64'h8);
        check("stream_pc8", bus.out_pc, 64'h8);
        drive(0, 64'h0);
        drive(0, 64'h0);
        check("stream_order", 64'(emitted.size() == 3 && emitted[0] == 64'h0 &&
                                  emitted[1] == 64'h4 && emitted[2] == 64'h8), 64'd1);

        // Stall fills the skid, release drains in order
        bus.out_ready = 1'b0;
        drive(1, 64'h10);
        check("stall_ready_after1", 64'(bus.in_ready), 64'd1);
        drive(1, 64'h14);
        check("stall_ready_after2", 64'(bus.in_ready), 64'd0);
        drive(0, 64'h0);
        drive(0, 64'h0);
        check("stall_hold_pc", bus.out_pc, 64'h10);
        bus.out_ready = 1'b1;
        drive(0, 64'h0);
        check("release_second", bus.out_pc, 64'h14);
        drive(0, 64'h0);
        check("release_empty", 64'(bus.out_valid), 64'd0);

        // Flush with both entries full
        bus.out_ready = 1'b0;
        drive(1, 64'h10);
        drive(1, 64'h14);
        drive(0, 64'h0);
        flush = 1'b1;
        drive(0, 64'h0);
        flush = 1'b0;
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        check("flush_in_ready",  64'(bus.in_ready),  64'd1);
        bus.out_ready = 1'b1;
        drive(0, 64'h0);
        drive(0, 64'h0);
        check("flush_no_10", 64'(count_pc(64'h10)), 64'd1);
        check("flush_no_14", 64'(count_pc(64'h14)), 64'd1);

        // Flush coincident with an incoming beat
        flush = 1'b1;
        drive(1, 64'h20);
        flush = 1'b0;
        check("flush_in_dropped", 64'(bus.out_valid), 64'd0);
        drive(1, 64'h24);
        check("after_flush_pc", bus.out_pc, 64'h24);
        drive(0, 64'h0);
        check("no_20_emitted", 64'(count_pc(64'h20)), 64'd0);
        check("24_emitted",    64'(count_pc(64'h24)), 64'd1);

`ifdef IF_ID_PERF_CNT_EN
        // 5 stall cycles then 2 flush cycles from a fresh reset
        reset = 1'b1;
        drive(0, 64'h0);
        reset = 1'b0;
        bus.out_ready = 1'b0;
        drive(1, 64'h40);
        repeat (5) drive(0, 64'h0);
        bus.out_ready = 1'b1;
        flush = 1'b1;
        repeat (2) drive(0, 64'h0);
        flush = 1'b0;
        check("perf_stall5",  64'(stall_cnt),  64'd5);
        check("perf_flush2",  64'(flush_cnt),  64'd2);
        check("perf_stall_sat", 64'(stall_cnt2), 64'd3);
        check("perf_flush2_small", 64'(flush_cnt2), 64'd2);
`endif

        // Randomised traffic with occasional flushes
        for (int i = 0; i < 3000; i++) begin
            bus.out_ready = ($urandom_range(0, 9) < 6);
            flush         = ($urandom_range(0, 99) < 3);
            drive($urandom_range(0, 9) < 7, {$urandom, $urandom});
        end
        flush = 1'b0;

        // Drain, bounded
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() > 0; i++) drive(0, 64'h0);
        check("drain_empty", 64'(q.size()), 64'd0);
        check("drain_out_valid", 64'(bus.out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
